// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access controller.
//   - load/store format encodings (LF_*, SF_*)
//   - access FSM state type
//   - requester port identifiers (PORT_CPU / PORT_DBG)
//   - helpers returning log2 access size and alignment status
package dmem_pkg;

    localparam logic [2:0] LF_LB  = 3'b000;
    localparam logic [2:0] LF_LH  = 3'b001;
    localparam logic [2:0] LF_LW  = 3'b010;
    localparam logic [2:0] LF_LD  = 3'b011;
    localparam logic [2:0] LF_LBU = 3'b100;
    localparam logic [2:0] LF_LHU = 3'b101;
    localparam logic [2:0] LF_LWU = 3'b110;
    localparam logic [2:0] LF_ILL = 3'b111;

    localparam logic [1:0] SF_SB = 2'b00;
    localparam logic [1:0] SF_SH = 2'b01;
    localparam logic [1:0] SF_SW = 2'b10;
    localparam logic [1:0] SF_SD = 2'b11;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        CAPT   = 2'd3
    } state_t;

    // log2 of the access size in bytes (0=byte .. 3=doubleword)
    function automatic logic [1:0] access_size(input logic we, input logic [2:0] lf,
                                               input logic [1:0] sf);
        logic [1:0] sz;
        if (we) begin
            sz = sf;
        end else begin
            case (lf)
                LF_LB, LF_LBU: sz = 2'd0;
                LF_LH, LF_LHU: sz = 2'd1;
                LF_LW, LF_LWU: sz = 2'd2;
                LF_LD:         sz = 2'd3;
                default:       sz = 2'd0;
            endcase
        end
        return sz;
    endfunction

    // natural alignment check on the low address bits
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
        logic mis;
        case (sz)
            2'd0:    mis = 1'b0;
            2'd1:    mis = a[0];
            2'd2:    mis = |a[1:0];
            2'd3:    mis = |a[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational lane formatter.
//   Store side: st_format/st_offset/st_data -> st_be (byte enables), st_lanes (replicated data)
//   Load side : ld_format/ld_offset/ld_word (current SRAM word)/ld_lo (captured low word)
//               -> ld_data, little-endian extract with sign/zero extension to 64 bits
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  st_format,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [2:0]  ld_format,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    input  logic [31:0] ld_lo,
    output logic [63:0] ld_data
);

    logic [31:0] shifted_s;

    // Store byte enables and lane replication
    always_comb begin
        st_be    = 4'b0000;
        st_lanes = 32'h0000_0000;
        case (st_format)
            SF_SB: begin
                st_be    = 4'b0001 << st_offset;
                st_lanes = {4{st_data[7:0]}};
            end
            SF_SH: begin
                st_be    = 4'b0011 << {st_offset[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
            end
            SF_SW, SF_SD: begin
                st_be    = 4'b1111;
                st_lanes = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_lanes = 32'h0000_0000;
            end
        endcase
    end

    // Load extract: shift the addressed lane down to bit 0, then extend
    always_comb begin
        shifted_s = ld_word >> {ld_offset, 3'b000};
        ld_data   = 64'h0;
        case (ld_format)
            LF_LB:   ld_data = {{56{shifted_s[7]}}, shifted_s[7:0]};
            LF_LH:   ld_data = {{48{shifted_s[15]}}, shifted_s[15:0]};
            LF_LW:   ld_data = {{32{shifted_s[31]}}, shifted_s};
            LF_LD:   ld_data = {ld_word, ld_lo};
            LF_LBU:  ld_data = {56'h0, shifted_s[7:0]};
            LF_LHU:  ld_data = {48'h0, shifted_s[15:0]};
            LF_LWU:  ld_data = {32'h0, shifted_s};
            default: ld_data = 64'h0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: shares one single-port 32-bit byte-enabled SRAM between a CPU
// MEM-stage port (cpu_*) and a debug/loader port (dbg_*).
//   cpu_/dbg_ req_valid/ready/we/load_format/store_format/addr/wdata : request side
//   cpu_/dbg_ rsp_valid/rsp_err/rdata                               : response side
//   mem_en/we/be/addr/wdata, mem_rdata                             : SRAM interface
// Checks range/alignment/format at acceptance, splits doublewords into two beats,
// extends load data and returns one response pulse per accepted request.
// Optional macro DMEM_RR_ARB_EN: round-robin arbitration instead of CPU priority.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_load_format,
    input  logic [1:0]        cpu_store_format,
    input  logic [63:0]       cpu_addr,
    input  logic [63:0]       cpu_wdata,
    output logic              cpu_rsp_valid,
    output logic              cpu_rsp_err,
    output logic [63:0]       cpu_rdata,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_we,
    input  logic [2:0]        dbg_load_format,
    input  logic [1:0]        dbg_store_format,
    input  logic [63:0]       dbg_addr,
    input  logic [63:0]       dbg_wdata,
    output logic              dbg_rsp_valid,
    output logic              dbg_rsp_err,
    output logic [63:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t        state_r;
    logic          owner_r;
    logic          req_we_r;
    logic [2:0]    req_lf_r;
    logic [1:0]    req_off_r;
    logic          req_double_r;
    logic [31:0]   req_hi_r;
    logic [31:0]   lo_r;
`ifdef DMEM_RR_ARB_EN
    logic          last_r;
`endif

    logic          grant_cpu_s, grant_dbg_s, sel_dbg_s, accept_s;
    logic          req_we_s;
    logic [2:0]    req_lf_s;
    logic [1:0]    req_sf_s;
    logic [63:0]   req_addr_s;
    logic [63:0]   req_wdata_s;
    logic [1:0]    req_size_s;
    logic          req_err_s;
    logic [3:0]    st_be_s;
    logic [31:0]   st_lanes_s;
    logic [63:0]   ld_data_s;

    // Arbitration: decide which valid port may hand over a request
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dbg_s = 1'b0;
`ifdef DMEM_RR_ARB_EN
        if (cpu_req_valid && dbg_req_valid) begin
            grant_dbg_s = (last_r == PORT_CPU);
            grant_cpu_s = (last_r == PORT_DBG);
        end else begin
            grant_cpu_s = cpu_req_valid;
            grant_dbg_s = dbg_req_valid;
        end
`else
        grant_cpu_s = cpu_req_valid;
        grant_dbg_s = !cpu_req_valid && dbg_req_valid;
`endif
    end

    // Ready is only offered in IDLE; reset_n gating keeps it low while in reset
    assign cpu_req_ready = reset_n && (state_r == IDLE) && grant_cpu_s;
    assign dbg_req_ready = reset_n && (state_r == IDLE) && grant_dbg_s;
    assign accept_s      = cpu_req_ready || dbg_req_ready;
    assign sel_dbg_s     = grant_dbg_s;

    // Request mux and acceptance-time error check (format, range, alignment)
    always_comb begin
        req_we_s    = cpu_we;
        req_lf_s    = cpu_load_format;
        req_sf_s    = cpu_store_format;
        req_addr_s  = cpu_addr;
        req_wdata_s = cpu_wdata;
        if (sel_dbg_s) begin
            req_we_s    = dbg_we;
            req_lf_s    = dbg_load_format;
            req_sf_s    = dbg_store_format;
            req_addr_s  = dbg_addr;
            req_wdata_s = dbg_wdata;
        end else begin
            req_we_s    = cpu_we;
        end
        req_size_s = access_size(req_we_s, req_lf_s, req_sf_s);
        req_err_s  = (!req_we_s && (req_lf_s == LF_ILL))
                   || (|req_addr_s[63:ADDR_W])
                   || is_misaligned(req_size_s, req_addr_s[2:0]);
    end

    dmem_lane_fmt u_lane_fmt (
        .st_format (req_sf_s),
        .st_offset (req_addr_s[1:0]),
        .st_data   (req_wdata_s[31:0]),
        .st_be     (st_be_s),
        .st_lanes  (st_lanes_s),
        .ld_format (req_lf_r),
        .ld_offset (req_off_r),
        .ld_word   (mem_rdata),
        .ld_lo     (lo_r),
        .ld_data   (ld_data_s)
    );

    // Access FSM with registered SRAM strobes and responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            owner_r       <= PORT_CPU;
            req_we_r      <= 1'b0;
            req_lf_r      <= 3'b000;
            req_off_r     <= 2'b00;
            req_double_r  <= 1'b0;
            req_hi_r      <= 32'h0;
            lo_r          <= 32'h0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_err   <= 1'b0;
            cpu_rdata     <= 64'h0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_err   <= 1'b0;
            dbg_rdata     <= 64'h0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_be        <= 4'b0000;
            mem_addr      <= '0;
            mem_wdata     <= 32'h0;
`ifdef DMEM_RR_ARB_EN
            last_r        <= PORT_DBG;
`endif
        end else begin
            cpu_rsp_valid <= 1'b0;
            dbg_rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r      <= sel_dbg_s;
                        req_we_r     <= req_we_s;
                        req_lf_r     <= req_lf_s;
                        req_off_r    <= req_addr_s[1:0];
                        req_double_r <= (req_size_s == 2'd3);
                        req_hi_r     <= req_wdata_s[63:32];
`ifdef DMEM_RR_ARB_EN
                        last_r       <= sel_dbg_s;
`endif
                        if (req_err_s) begin
                            // rejected requests answer next cycle without touching SRAM
                            if (sel_dbg_s) begin
                                dbg_rsp_valid <= 1'b1;
                                dbg_rsp_err   <= 1'b1;
                                dbg_rdata     <= 64'h0;
                            end else begin
                                cpu_rsp_valid <= 1'b1;
                                cpu_rsp_err   <= 1'b1;
                                cpu_rdata     <= 64'h0;
                            end
                        end else begin
                            state_r   <= ACC_LO;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we_s;
                            mem_be    <= req_we_s ? st_be_s : 4'b1111;
                            mem_addr  <= req_addr_s[ADDR_W-1:2];
                            mem_wdata <= req_we_s ? st_lanes_s : 32'h0;
                        end
                    end
                end
                ACC_LO: begin
                    if (req_double_r) begin
                        state_r   <= ACC_HI;
                        mem_addr  <= mem_addr + {{(ADDR_W-3){1'b0}}, 1'b1};
                        mem_be    <= 4'b1111;
                        mem_wdata <= req_we_r ? req_hi_r : 32'h0;
                    end else begin
                        state_r   <= CAPT;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                    end
                end
                ACC_HI: begin
                    // the low word of a doubleword read arrives now
                    lo_r      <= mem_rdata;
                    state_r   <= CAPT;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_be    <= 4'b0000;
                    mem_wdata <= 32'h0;
                end
                CAPT: begin
                    state_r <= IDLE;
                    if (owner_r == PORT_DBG) begin
                        dbg_rsp_valid <= 1'b1;
                        dbg_rsp_err   <= 1'b0;
                        dbg_rdata     <= req_we_r ? 64'h0 : ld_data_s;
                    end else begin
                        cpu_rsp_valid <= 1'b1;
                        cpu_rsp_err   <= 1'b0;
                        cpu_rdata     <= req_we_r ? 64'h0 : ld_data_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: self-checking bench for dmem_access_ctrl. A byte-array
// reference model computes expected load data, error status and latency; a simple
// behavioural SRAM sits on the mem_* interface.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req_valid, cpu_req_ready, cpu_we;
    logic [2:0]  cpu_load_format;
    logic [1:0]  cpu_store_format;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rsp_valid, cpu_rsp_err;
    logic        dbg_req_valid, dbg_req_ready, dbg_we;
    logic [2:0]  dbg_load_format;
    logic [1:0]  dbg_store_format;
    logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_rsp_valid, dbg_rsp_err;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] sram [0:1023];
    logic [7:0]  ref_mem [0:4095];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
        .cpu_load_format(cpu_load_format), .cpu_store_format(cpu_store_format),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_err(cpu_rsp_err), .cpu_rdata(cpu_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_we(dbg_we),
        .dbg_load_format(dbg_load_format), .dbg_store_format(dbg_store_format),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_err(dbg_rsp_err), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // behavioural single-port SRAM, read data one cycle after the strobe
    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_en) begin
            if (mem_we) begin
                w = sram[mem_addr];
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                sram[mem_addr] <= w;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic port, input logic v, input logic we, input logic [2:0] lf,
                         input logic [1:0] sf, input logic [63:0] a, input logic [63:0] w);
        if (port) begin
            dbg_req_valid = v; dbg_we = we; dbg_load_format = lf;
            dbg_store_format = sf; dbg_addr = a; dbg_wdata = w;
        end else begin
            cpu_req_valid = v; cpu_we = we; cpu_load_format = lf;
            cpu_store_format = sf; cpu_addr = a; cpu_wdata = w;
        end
    endtask

    // reference model: applies the access to ref_mem and predicts the response
    task automatic model(input logic we, input logic [2:0] lf, input logic [1:0] sf,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic err, output logic [63:0] rdata,
                         output int lat, output int size);
        logic sgn;
        logic [63:0] val;
        sgn = 1'b0; rdata = 64'h0; size = 0;
        if (we) size = 1 << sf;
        else begin
            case (lf)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: begin size = 4; sgn = 1'b1; end
                3'd3: size = 8;
                3'd4: size = 1;
                3'd5: size = 2;
                3'd6: size = 4;
                default: size = 0;
            endcase
        end
        err = (!we && lf == 3'd7) || (addr >= 64'd4096)
              || (size != 0 && (addr % 64'(size)) != 64'd0);
        lat = err ? 1 : ((size == 8) ? 4 : 3);
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++)
                    ref_mem[int'(addr[11:0]) + i] = wdata[8*i +: 8];
            end else begin
                val = 64'h0;
                for (int i = 0; i < size; i++)
                    val = val | (64'(ref_mem[int'(addr[11:0]) + i]) << (8*i));
                if (sgn && size < 8 && val[8*size-1])
                    val = val | ~((64'd1 << (8*size)) - 64'd1);
                rdata = val;
            end
        end
    endtask

    task automatic access(input logic port, input logic we, input logic [2:0] lf,
                          input logic [1:0] sf, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] got);
        logic e_err, g_err, rdy, err_mem, other;
        logic [63:0] e_rdata;
        int e_lat, size, lat, n;
        logic [3:0] e_be;
        logic [31:0] e_w;
        logic [47:0] beat1;
        logic [42:0] beat2;
        model(we, lf, sf, addr, wdata, e_err, e_rdata, e_lat, size);
        e_be = 4'hF;
        e_w  = 32'h0;
        if (we && size == 1) begin e_be = 4'b0001 << addr[1:0]; e_w = 32'(wdata[7:0]) * 32'h0101_0101; end
        if (we && size == 2) begin e_be = 4'b0011 << addr[1:0]; e_w = 32'(wdata[15:0]) * 32'h0001_0001; end
        if (we && size >= 4) e_w = wdata[31:0];
        @(negedge clk);
        drive(port, 1'b1, we, lf, sf, addr, wdata);
        #1;
        n = 0;
        rdy = port ? dbg_req_ready : cpu_req_ready;
        while (!rdy && n < 8) begin
            @(negedge clk); #1; n++;
            rdy = port ? dbg_req_ready : cpu_req_ready;
        end
        chk("accept", {63'h0, rdy}, 64'd1);
        if (!rdy) begin
            drive(port, 1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0);
            got = 64'h0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        drive(port, 1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0);
        lat = 0; got = 64'h0; g_err = 1'b0; err_mem = 1'b0; other = 1'b0;
        beat1 = '0; beat2 = '0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (k == 1) beat1 = {mem_en, mem_we, mem_addr, mem_be, (we ? mem_wdata : 32'h0)};
            if (k == 2) beat2 = {mem_en, mem_addr, (we ? mem_wdata : 32'h0)};
            if (mem_en && e_err) err_mem = 1'b1;
            if (port ? dbg_rsp_valid : cpu_rsp_valid) begin
                lat   = k;
                got   = port ? dbg_rdata : cpu_rdata;
                g_err = port ? dbg_rsp_err : cpu_rsp_err;
            end
            if (port ? cpu_rsp_valid : dbg_rsp_valid) other = 1'b1;
            @(negedge clk);
        end
        chk("rsp_pulse", {63'h0, (port ? dbg_rsp_valid : cpu_rsp_valid)}, 64'd0);
        chk("latency", 64'(lat), 64'(e_lat));
        chk("rsp_err", {63'h0, g_err}, {63'h0, e_err});
        chk("rdata", got, e_rdata);
        chk("other_port_rsp", {63'h0, other}, 64'd0);
        if (e_err) chk("err_no_mem", {63'h0, err_mem}, 64'd0);
        else chk("beat1", 64'(beat1), 64'({1'b1, we, addr[11:2], e_be, e_w}));
        if (!e_err && size == 8)
            chk("beat2", 64'(beat2), 64'({1'b1, addr[11:2] + 10'd1, (we ? wdata[63:32] : 32'h0)}));
    endtask

    initial begin
        logic [63:0] got;
        logic gseq [4];
        int ng;
        logic seen;
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
        mem_rdata = 32'h0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_ctrl", {58'h0, cpu_req_ready, dbg_req_ready, cpu_rsp_valid, cpu_rsp_err,
                           dbg_rsp_valid, dbg_rsp_err}, 64'd0);
        chk("reset_rdata", cpu_rdata | dbg_rdata, 64'd0);
        chk("reset_mem", {17'h0, mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);

        // both ports valid every cycle: observe the grant order of 4 handshakes
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'd2, 2'd0, 64'h10, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 2'd0, 64'h10, 64'h0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (cpu_req_ready) begin gseq[ng] = 1'b0; ng++; end
            else if (dbg_req_ready) begin gseq[ng] = 1'b1; ng++; end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0);
        chk("arb_grants", 64'(ng), 64'd4);
        for (int i = 0; i < ng; i++) begin
`ifdef DMEM_RR_ARB_EN
            chk("arb_order", {63'h0, gseq[i]}, 64'(i % 2));
`else
            chk("arb_order", {63'h0, gseq[i]}, 64'd0);
`endif
        end
        repeat (6) @(negedge clk);

        // directed cases
        sram[4] = 32'h8000_00F0;
        ref_mem[16] = 8'hF0; ref_mem[17] = 8'h00; ref_mem[18] = 8'h00; ref_mem[19] = 8'h80;
        access(1'b0, 1'b0, 3'd0, 2'd0, 64'h010, 64'h0, got);
        chk("lb_0x010", got, 64'hFFFF_FFFF_FFFF_FFF0);
        access(1'b0, 1'b0, 3'd4, 2'd0, 64'h013, 64'h0, got);
        chk("lbu_0x013", got, 64'h80);
        access(1'b0, 1'b0, 3'd2, 2'd0, 64'h010, 64'h0, got);
        chk("lw_0x010", got, 64'hFFFF_FFFF_8000_00F0);
        access(1'b0, 1'b1, 3'd0, 2'd3, 64'h020, 64'h1122_3344_5566_7788, got);
        access(1'b0, 1'b0, 3'd3, 2'd0, 64'h020, 64'h0, got);
        chk("ld_0x020", got, 64'h1122_3344_5566_7788);
        access(1'b0, 1'b1, 3'd0, 2'd1, 64'h006, 64'hBEEF, got);
        access(1'b0, 1'b0, 3'd1, 2'd0, 64'h006, 64'h0, got);
        chk("lh_0x006", got, 64'hFFFF_FFFF_FFFF_BEEF);
        access(1'b0, 1'b0, 3'd2, 2'd0, 64'h002, 64'h0, got);
        access(1'b0, 1'b0, 3'd3, 2'd0, 64'h1004, 64'h0, got);
        access(1'b0, 1'b0, 3'd7, 2'd0, 64'h000, 64'h0, got);
        access(1'b1, 1'b0, 3'd6, 2'd0, 64'h010, 64'h0, got);
        chk("dbg_lwu_0x010", got, 64'h8000_00F0);

        // reset during the high beat of a doubleword load
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 2'd0, 64'h020, 64'h0);
        #1;
        chk("rst_accept", {63'h0, cpu_req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", {17'h0, mem_en, mem_we, mem_be, mem_addr, mem_wdata}
                            | 64'({cpu_rsp_valid, cpu_rsp_err}) | cpu_rdata, 64'd0);
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (cpu_rsp_valid) seen = 1'b1; end
        reset_n = 1'b1;
        repeat (4) begin @(negedge clk); if (cpu_rsp_valid) seen = 1'b1; end
        chk("rst_no_rsp", {63'h0, seen}, 64'd0);
        access(1'b0, 1'b0, 3'd2, 2'd0, 64'h010, 64'h0, got);
        chk("post_rst_lw", got, 64'hFFFF_FFFF_8000_00F0);

        // randomized traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            logic p, we;
            logic [2:0] lf;
            logic [1:0] sf;
            logic [63:0] a, w;
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            lf = 3'($urandom_range(0, 7));
            sf = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) a = a & ~64'd7;
            if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(12, 63));
            w  = {$urandom, $urandom};
            access(p, we, lf, sf, a, w, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencer and arbiter in front of a single-port, 32-bit, byte-enabled synchronous data SRAM. It shares that SRAM between the pipeline MEM-stage port (cpu_) and a debug/loader port (dbg_). For each access it checks alignment and range, builds byte enables and write lanes, and splits doublewords into two beats. It sign/zero-extends load data and returns one response pulse per accepted request.

Parameters:
ADDR_W, 12, byte-address width of the data memory (4 KiB); SRAM word address is ADDR_W-2 bits

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  CPU request accepted this cycle (valid&&ready)
cpu_we  in  1  1=store, 0=load
cpu_load_format  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal
cpu_store_format  in  2  00 sb, 01 sh, 10 sw, 11 sd
cpu_addr  in  64  byte address
cpu_wdata  in  64  store data, LSB-aligned
cpu_rsp_valid  out  1  one-cycle response pulse
cpu_rsp_err  out  1  misaligned/out-of-range/illegal; qualified by rsp_valid
cpu_rdata  out  64  extended load data (0 for stores/errors)
dbg_req_valid, dbg_req_ready, dbg_we, dbg_load_format, dbg_store_format, dbg_addr, dbg_wdata, dbg_rsp_valid, dbg_rsp_err, dbg_rdata: identical to cpu_*
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write
mem_be  out  4  byte enables, bit i = lane [8i+7:8i]
mem_addr  out  ADDR_W-2  SRAM word address
mem_wdata  out  32  write lanes
mem_rdata  in  32  read data, valid cycle after mem_en&&!mem_we

Behaviour:
- Reset: state IDLE. All outputs 0: ready, rsp_valid, rsp_err, rdata, mem_*. Arbitration pointer = "dbg last".
- FSM states: IDLE, ACC_LO, ACC_HI, CAPT.
- IDLE: the granted port sees ready=1 (combinational from the valids); the other port sees 0. Default grant is strict CPU priority; dbg is granted only when cpu_req_valid=0. On a handshake, latch the request and owner.
- Error check at acceptance, in priority order:
  - illegal load format (111);
  - addr[63:ADDR_W]!=0;
  - misalignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
- On error: stay in IDLE, issue no SRAM access, and set rsp_valid=1, err=1, rdata=0 next cycle.
- ACC_LO: mem_en=1; mem_addr=addr[ADDR_W-1:2].
  - sb: be=0001<<addr[1:0], wdata={4{b}}.
  - sh: be=0011<<{addr[1],1'b0}, wdata={2{h}}.
  - sw: be=1111.
  - sd/ld: be=1111 with low word.
  - Loads use mem_we=0, be=1111.
  - Next state is ACC_HI for doubleword, otherwise CAPT.
- ACC_HI: mem_addr+1, high word; mem_rdata (low word) captured into lo_reg. Next state CAPT.
- CAPT: mem_en=0. Format the load little-endian from lane addr[1:0]: lb/lh/lw sign-extend to 64, lbu/lhu/lwu zero-extend, ld={mem_rdata,lo_reg}. Register it into the owner's rdata; owner rsp_valid=1 next cycle (err=0). Go to IDLE.
- Latency from the accept cycle c0 to rsp_valid:
  - non-double: c3;
  - double: c4;
  - error: c1.
  - Stores follow the same timing with rdata=0.
- Back-to-back: a new request may be accepted in the cycle rsp_valid is high.
- rsp_valid is a 1-cycle pulse with no backpressure. rdata/err hold until that port's next response.
- Reset mid-operation: abort immediately, no response. A completed ACC_LO write of a doubleword remains in SRAM.
- A requester must hold its request stable while valid&&!ready.

Optional Feature:
DMEM_RR_ARB_EN.
- Defined: round-robin arbitration. When both ports are valid in IDLE, grant the port not granted last; the pointer updates on each handshake. After reset CPU wins first.
- Undefined: strict CPU priority, and the pointer logic is absent.

Decomposition:
- Package dmem_pkg:
  - load/store format constants (LF_LB..LF_LWU, SF_SB..SF_SD);
  - FSM state enum;
  - port-id constants PORT_CPU/PORT_DBG.
- Sub-module dmem_lane_fmt: combinational store lane/byte-enable builder and load extract/extend. The FSM and arbitration stay in dmem_access_ctrl.

Test Plan:
- Preload word 0x8000_00F0 at 0x010. cpu lb @0x010 -> rdata 0xFFFF_FFFF_FFFF_FFF0 at c3. lbu @0x013 -> 0x80. lw @0x010 -> 0xFFFF_FFFF_8000_00F0.
- cpu sd 0x1122_3344_5566_7788 @0x020, then ld @0x020 -> two writes (be=1111, words 8, 9); response at c4; ld returns 0x1122334455667788.
- cpu sh 0xBEEF @0x006 -> mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=1. lh @0x006 -> 0xFFFF_FFFF_FFFF_BEEF.
- Error cases, each with rsp_err=1 at c1 and no mem_en:
  - lw @0x002;
  - ld @0x1004;
  - load_format=111.
- Both valid every cycle for 4 requests:
  - default build: CPU always granted, dbg never;
  - DMEM_RR_ARB_EN build: grants alternate cpu, dbg, cpu, dbg.
- Assert reset_n low during ACC_HI of ld -> outputs 0 immediately, no rsp_valid. After release, a new lw completes normally at c3.
